reg_file_2r1w: RTL and testbench
================================

// Module: reg_file_2r1w
// PURPOSE
// - Parametrised CPU register file: two combinational read ports (RS, RT), one synchronous write port.
// - Adds over the previous generation: separate write address, hardwired zero register,
//   write-to-read bypass, and a sequenced clear (CLR) with a BUSY indication.
// - Sits in the decode stage. Feeds ALU operands and takes writeback from the final stage.
// PARAMETERS
// - WIDTH     32  data width of each register.
// - DEPTH     32  number of registers; power of two, >= 2.
// - AW        $clog2(DEPTH)  address width; derived, never overridden.
// - ZERO_REG  1   1: entry 0 always reads 0 and writes to it are dropped. 0: entry 0 is an ordinary register.
// - BYPASS    1   1: a same-cycle write is forwarded to a matching read port.
// PORTS
// - CLK   in   1      single clock; all state updates on the rising edge.
// - RSTN  in   1      asynchronous active-low reset.
// - RSA   in   AW     read address, port S.
// - RTA   in   AW     read address, port T.
// - WE    in   1      write enable.
// - WA    in   AW     write address.
// - WD    in   WIDTH  write data.
// - CLR   in   1      clear request; single-cycle pulse or level.
// - RSR   out  WIDTH  read data, port S; combinational.
// - RTR   out  WIDTH  read data, port T; combinational.
// - BUSY  out  1      high while a clear sweep is in progress.
// BEHAVIOUR
// - Reset (RSTN=0, asynchronous):
//   - all entries = 0; FSM = IDLE; sweep counter = 0; BUSY = 0.
//   - RSR and RTR therefore read 0.
// - Write:
//   - at posedge CLK with WE=1 and FSM=IDLE, mem[WA] <= WD.
//   - if ZERO_REG=1 and WA=0, the write is dropped.
// - Read: RSR = mem[RSA] and RTR = mem[RTA], with no clock latency. Priority order:
//   1. ZERO_REG=1 and address 0 -> 0.
//   2. FSM=SWEEP -> 0.
//   3. BYPASS=1 and WE=1 and WA==address -> WD.
//   4. Otherwise -> stored value.
// - Both read ports may address the same entry. Each port resolves independently.
// - FSM, two states:
//   - IDLE -> SWEEP when CLR=1 is sampled; the counter loads 0.
//   - SWEEP clears mem[cnt] <= 0 each cycle, then cnt++.
//   - SWEEP -> IDLE after clearing entry DEPTH-1, i.e. exactly DEPTH cycles in SWEEP.
// - BUSY = (FSM==SWEEP), registered.
//   - Rises on the edge after CLR is sampled.
//   - Falls on the edge that clears the last entry.
// - Boundary conditions:
//   - CLR while in SWEEP: ignored; the sweep is not restarted.
//   - WE while in SWEEP: the write is dropped, with no error flag. The upstream stage must stall on BUSY.
//   - WE and CLR in the same IDLE cycle: the write commits; the sweep then starts on the next cycle and clears it.
//   - RSTN asserted mid-sweep: immediate IDLE with all entries 0. No resume after reset.
//   - Counter is AW bits; its wrap at DEPTH-1 coincides with the SWEEP->IDLE transition.
// STRUCTURE
// - Shared package kgp_risc_pkg:
//   - REG_WIDTH=32 and REG_DEPTH=32.
//   - rf_state_t enum {RF_IDLE, RF_SWEEP}.
// - Storage is a flat array with async-reset flops (no RAM inference).
// - One natural sub-module: rf_read_port, implementing the priority chain above. Instantiate it twice (S and T).
// - The FSM, the counter and the write logic stay in the top module.
// TESTING
// - Zero register: WE=1, WA=0, WD=56; then RSA=0 -> RSR=0 and RTR=0 on every cycle.
// - Basic write/read: WE=1, WA=1, WD=64; after the edge, WE=0 and RSA=1 -> RSR=64.
//   Also set RTA=1 -> RTR=64 at the same time.
// - Bypass: WE=1, WA=19, WD=213142345, RSA=19 in the same cycle.
//   -> RSR=213142345 before the edge; RSR holds it after the edge with WE=0.
// - Clear sweep (DEPTH=32):
//   - preload r5=7. Pulse CLR for one cycle -> BUSY=1 for exactly 32 cycles.
//   - during the sweep, WE to r3 is dropped.
//   - afterwards, r5 and r3 both read 0.
// - Reset mid-sweep: assert RSTN=0 on sweep cycle 10 -> BUSY=0 asynchronously; all reads 0.
//   After release, WE to r2 = 0xA5A5A5A5 reads back correctly.
// - Parameter variant WIDTH=16, DEPTH=8, ZERO_REG=0: write r0=0x1234 -> RSA=0 reads 0x1234; CLR -> BUSY for 8 cycles.

Source files
------------

// File: rtl/kgp_risc_pkg.sv
// Shared definitions for the KGP RISC decode stage: default register-file
// geometry and the clear-sequencer state type.
package kgp_risc_pkg;

    localparam int REG_WIDTH = 32;
    localparam int REG_DEPTH = 32;

    typedef enum logic {
        RF_IDLE,
        RF_SWEEP
    } rf_state_t;

endpackage : kgp_risc_pkg

// File: rtl/rf_read_port.sv
// One combinational read port of the register file. It resolves the zero
// register, the clear sweep and write forwarding ahead of the stored value.
module rf_read_port #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic [AW-1:0]    addr,
    input  logic             sweeping,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [WIDTH-1:0] stored,
    output logic [WIDTH-1:0] data
);

    // NOTE: data gets a default before the chain so every path assigns it and
    // no latch is inferred.
    always_comb begin
        data = stored;
        if (ZERO_REG && (addr == '0)) begin
            data = '0;
        end else if (sweeping) begin
            data = '0;
        end else if (BYPASS && we && (wa == addr)) begin
            data = wd;
        end
    end

endmodule : rf_read_port

// File: rtl/reg_file_2r1w.sv
// Decode-stage register file: two combinational read ports, one synchronous
// write port, optional hardwired zero register and a sequenced clear sweep.
module reg_file_2r1w
    import kgp_risc_pkg::*;
#(
    parameter int  WIDTH    = REG_WIDTH,
    parameter int  DEPTH    = REG_DEPTH,
    parameter bit  ZERO_REG = 1'b1,
    parameter bit  BYPASS   = 1'b1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [AW-1:0]    rsa,
    input  logic [AW-1:0]    rta,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             clr,
    output logic [WIDTH-1:0] rsr,
    output logic [WIDTH-1:0] rtr,
    output logic             busy
);

    rf_state_t        state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             sweeping;
    logic             wr_en;

    assign sweeping = (state_q == RF_SWEEP);
    assign busy     = sweeping;
    assign wr_en    = we && (state_q == RF_IDLE) && !(ZERO_REG && (wa == '0));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter wraps from DEPTH-1 to 0 on the same edge the sweep ends.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RF_IDLE: begin
                if (clr) begin
                    state_d = RF_SWEEP;
                    cnt_d   = '0;
                end
            end
            RF_SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RF_IDLE;
                end
            end
            default: begin
                state_d = RF_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: the storage is a plain flop array, so the async reset clears every
    // entry; a RAM macro could not offer that.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (sweeping) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            mem[wa] <= wd;
        end
    end

    rf_read_port #(
        .WIDTH    (WIDTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_port_s (
        .addr     (rsa),
        .sweeping (sweeping),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .stored   (mem[rsa]),
        .data     (rsr)
    );

    rf_read_port #(
        .WIDTH    (WIDTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_port_t (
        .addr     (rta),
        .sweeping (sweeping),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .stored   (mem[rta]),
        .data     (rtr)
    );

endmodule : reg_file_2r1w

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: default 32x32 instance against an
// array-based reference model, plus a 16x8 instance without a zero register.
module tb_reg_file_2r1w;

    logic        clk = 1'b0;
    logic        rstn;

    // Default instance: WIDTH=32, DEPTH=32, ZERO_REG=1, BYPASS=1
    logic [4:0]  rsa, rta, wa;
    logic        we, clr;
    logic [31:0] wd, rsr, rtr;
    logic        busy;

    // Variant instance: WIDTH=16, DEPTH=8, ZERO_REG=0
    logic [2:0]  s_rsa, s_rta, s_wa;
    logic        s_we, s_clr;
    logic [15:0] s_wd, s_rsr, s_rtr;
    logic        s_busy;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: register contents plus remaining busy cycles. A clear
    // is modelled as wiping everything at once, which is indistinguishable
    // from outside since reads return 0 and writes are dropped while busy.
    logic [31:0] m_mem [32];
    int          busy_left;

    always #5 clk = ~clk;

    reg_file_2r1w u_dut (
        .clk  (clk),
        .rstn (rstn),
        .rsa  (rsa),
        .rta  (rta),
        .we   (we),
        .wa   (wa),
        .wd   (wd),
        .clr  (clr),
        .rsr  (rsr),
        .rtr  (rtr),
        .busy (busy)
    );

    reg_file_2r1w #(
        .WIDTH    (16),
        .DEPTH    (8),
        .ZERO_REG (1'b0),
        .BYPASS   (1'b1)
    ) u_dut_small (
        .clk  (clk),
        .rstn (rstn),
        .rsa  (s_rsa),
        .rta  (s_rta),
        .we   (s_we),
        .wa   (s_wa),
        .wd   (s_wd),
        .clr  (s_clr),
        .rsr  (s_rsr),
        .rtr  (s_rtr),
        .busy (s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0)                return 32'd0;
        if (busy_left > 0)            return 32'd0;
        if (we && (wa == a))          return wd;
        return m_mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        busy_left = 0;
    endtask

    task automatic model_edge();
        if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (we && (wa != 5'd0)) m_mem[wa] = wd;
            if (clr) begin
                for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
                busy_left = 32;
            end
        end
    endtask

    // Inputs are already driven; settle, compare, then take one clock edge.
    task automatic cycle();
        #1;
        chk("busy", {31'd0, busy}, {31'd0, busy_left > 0});
        chk("rsr", rsr, model_read(rsa));
        chk("rtr", rtr, model_read(rta));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; clr = 1'b0; wa = '0; wd = '0; rsa = '0; rta = '0;
    endtask

    initial begin
        int count;

        rstn = 1'b0;
        idle_inputs();
        s_we = 1'b0; s_clr = 1'b0; s_wa = '0; s_wd = '0; s_rsa = '0; s_rta = '0;
        model_reset();
        rsa = 5'd7; rta = 5'd31;
        #2;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_rsr", rsr, 32'd0);
        chk("reset_rtr", rtr, 32'd0);
        #1 rstn = 1'b1;

        // Zero register: the write to r0 never takes effect.
        we = 1'b1; wa = 5'd0; wd = 32'd56; rsa = 5'd0; rta = 5'd0;
        cycle();
        we = 1'b0;
        cycle();
        cycle();

        // Basic write then read on both ports.
        we = 1'b1; wa = 5'd1; wd = 32'd64;
        cycle();
        we = 1'b0; rsa = 5'd1; rta = 5'd1;
        cycle();
        chk("basic_rtr", rtr, 32'd64);

        // Bypass: forwarded before the edge, stored after it.
        we = 1'b1; wa = 5'd19; wd = 32'd213142345; rsa = 5'd19; rta = 5'd1;
        #1 chk("bypass_pre", rsr, 32'd213142345);
        cycle();
        we = 1'b0;
        cycle();

        // Randomised traffic with occasional clears.
        for (int i = 0; i < 300; i++) begin
            we  = ($urandom_range(0, 3) != 0);
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            rsa = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rta = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            clr = ($urandom_range(0, 59) == 0);
            cycle();
        end

        // Drain any sweep the random phase left running (bounded).
        idle_inputs();
        for (int i = 0; i < 40 && busy_left > 0; i++) cycle();
        chk("drained", {31'd0, busy}, 32'd0);

        // Clear sweep: preload r5, pulse CLR, write to r3 and re-pulse CLR mid-sweep.
        we = 1'b1; wa = 5'd5; wd = 32'd7; rsa = 5'd5; rta = 5'd3;
        cycle();
        we = 1'b0;
        cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        count = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            count++;
            we  = (i == 4);
            wa  = 5'd3;
            wd  = 32'hDEAD_BEEF;
            clr = (i == 8);
            cycle();
        end
        idle_inputs();
        chk("sweep_len", 32'(count), 32'd32);
        rsa = 5'd5; rta = 5'd3;
        cycle();
        chk("r5_cleared", rsr, 32'd0);
        chk("r3_dropped", rtr, 32'd0);

        // WE and CLR in the same idle cycle: write commits, sweep clears it.
        we = 1'b1; wa = 5'd9; wd = 32'h1357_9BDF; clr = 1'b1; rsa = 5'd9; rta = 5'd9;
        cycle();
        we = 1'b0; clr = 1'b0;
        for (int i = 0; i < 40 && busy_left > 0; i++) cycle();
        cycle();
        chk("we_clr_r9", rsr, 32'd0);

        // Reset in sweep cycle 10.
        we = 1'b1; wa = 5'd12; wd = 32'h0BAD_F00D;
        cycle();
        we = 1'b0; clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        rstn = 1'b0;
        model_reset();
        rsa = 5'd12; rta = 5'd5;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_rsr", rsr, 32'd0);
        chk("rst_mid_rtr", rtr, 32'd0);
        rstn = 1'b1;
        we = 1'b1; wa = 5'd2; wd = 32'hA5A5_A5A5;
        cycle();
        we = 1'b0; rsa = 5'd2; rta = 5'd12;
        cycle();
        chk("post_rst_r2", rsr, 32'hA5A5_A5A5);
        chk("no_resume", {31'd0, busy}, 32'd0);

        // Variant WIDTH=16, DEPTH=8, ZERO_REG=0: r0 is an ordinary register.
        s_we = 1'b1; s_wa = 3'd0; s_wd = 16'h1234;
        cycle();
        s_we = 1'b0; s_rsa = 3'd0; s_rta = 3'd0;
        #1;
        chk("small_r0", {16'd0, s_rsr}, 32'h0000_1234);
        chk("small_r0_t", {16'd0, s_rtr}, 32'h0000_1234);
        s_clr = 1'b1;
        cycle();
        s_clr = 1'b0;
        count = 0;
        for (int i = 0; i < 20; i++) begin
            if (!s_busy) break;
            count++;
            cycle();
        end
        chk("small_sweep_len", 32'(count), 32'd8);
        #1;
        chk("small_r0_cleared", {16'd0, s_rsr}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_reg_file_2r1w
